dense_train_ctrl: RTL and testbench
===================================

// Module: dense_train_ctrl
// PURPOSE
//  Sequencer for one dense_layer training step: zero_grad once, then per sample run_forward ->
//  load_backward -> run_backward, repeated BATCH_SIZE times, then update (optimizer + transpose).
//  Sits between the top-level train FSM / data feeders and dense_layer; owns every dense_layer control.
// PARAMETERS
//  BATCH_SIZE  8   samples accumulated into the gradient RAM before one update (>=1)
//  CNT_W       4   sample counter width; must satisfy 2**CNT_W > BATCH_SIZE
// PORTS
//  clk              in   1      clock
//  rst_n            in   1      asynchronous active-low reset
//  start            in   1      begin one training step (sampled in IDLE only)
//  abort            in   1      cancel current step, return to IDLE
//  fwd_data_valid   in   1      upstream is presenting d_forward for the next sample
//  bwd_data_valid   in   1      loss block is presenting d_backward for the current sample
//  fwd_data_ack     out  1      1-cycle pulse: d_forward consumed
//  bwd_data_ack     out  1      1-cycle pulse: d_backward consumed
//  zero_grad        out  1      level to dense_layer
//  run_forward      out  1      level to dense_layer
//  load_backward    out  1      1-cycle pulse to dense_layer
//  run_backward     out  1      level to dense_layer
//  update           out  1      level to dense_layer
//  valid_zero_grad  in   1      from dense_layer
//  valid_forward    in   1      from dense_layer
//  valid_backward   in   1      from dense_layer
//  valid_update     in   1      from dense_layer
//  busy             out  1      high in every state except IDLE
//  step_done        out  1      1-cycle pulse when update completes
//  sample_cnt       out  CNT_W  index of sample in progress, 0..BATCH_SIZE-1
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, sample_cnt 0. All outputs registered (state-decoded flops).
//  States: IDLE, ZERO, FWD_WAIT, FWD, BWD_WAIT, LOAD, BWD, UPD.
//  IDLE: start=1 -> ZERO next cycle; start ignored elsewhere.
//  ZERO: zero_grad held high until valid_zero_grad=1; then drop zero_grad, -> FWD_WAIT.
//  FWD_WAIT: fwd_data_valid=1 -> assert run_forward and fwd_data_ack (ack 1 cycle only), -> FWD.
//  FWD: run_forward held until valid_forward=1; run_forward low next cycle, -> BWD_WAIT.
//  BWD_WAIT: bwd_data_valid=1 -> load_backward pulse + bwd_data_ack pulse, -> LOAD.
//  LOAD: single cycle (d_forward_buf_delay settles); assert run_backward, -> BWD.
//  BWD: run_backward held until valid_backward=1; then if sample_cnt==BATCH_SIZE-1 ->
//   UPD, sample_cnt<=0; else sample_cnt+1, -> FWD_WAIT.
//  UPD: update held until valid_update=1; then update low, step_done pulse, -> IDLE.
//  Invariant: at most one of zero_grad/run_forward/run_backward/update high in any cycle;
//   every run level drops exactly one cycle after its valid is seen (valid is comb. of run).
//  Latency: IDLE->zero_grad high = 1 cycle after start; valid_x -> next action >= 1 cycle.
//  Waits are unbounded: no timeout; valid inputs outside their own state are ignored.
//  abort: highest priority; any state -> IDLE next cycle, all levels low, sample_cnt 0,
//   no acks, no step_done. Abort during UPD leaves W/V partially written (caller's problem).
//  abort and start same cycle in IDLE: stay IDLE.
//  Mid-operation reset: asynchronous, same as power-on; dense_layer sub-counters clear on
//   their own run deassertion.
//  BATCH_SIZE=1: BWD goes directly to UPD after the first sample.
// STRUCTURE
//  Shared package/header (consts_train.vh): state encoding localparams DTC_IDLE..DTC_UPD
//   (3 bits), default BATCH_SIZE.
//  Single module, no sub-module; state register + sample counter + registered output decode.
// TESTING
//  Bench models dense_layer valids as run delayed by fixed latency N (randomise 1..20).
//  1 BATCH_SIZE=2, feeds always valid: start -> order ZERO,F,L,B,F,L,B,U; step_done once; busy 0 after.
//  2 bwd_data_valid held low 50 cycles in BWD_WAIT -> no load_backward/run_backward; resumes on 1.
//  3 abort asserted while run_backward high, sample_cnt=1 -> next cycle all levels 0, IDLE, cnt 0.
//  4 valid_forward pulsed in ZERO / BWD states -> no state change, no spurious acks.
//  5 rst_n low mid-UPD -> outputs 0 asynchronously; after release, start runs full step cleanly.
//  6 Assertion over all tests: one-hot-or-zero on run levels; acks never 2 consecutive cycles.

Source files
------------

// File: rtl/dense_train_ctrl_pkg.sv
// Shared types and defaults for the dense_layer training-step sequencer.
// State encoding and batch defaults live here so the train FSM can reuse them.
package dense_train_ctrl_pkg;

  typedef enum logic [2:0] {
    DTC_IDLE     = 3'd0,
    DTC_ZERO     = 3'd1,
    DTC_FWD_WAIT = 3'd2,
    DTC_FWD      = 3'd3,
    DTC_BWD_WAIT = 3'd4,
    DTC_LOAD     = 3'd5,
    DTC_BWD      = 3'd6,
    DTC_UPD      = 3'd7
  } dtc_state_e;

  localparam int DTC_BATCH_SIZE = 8;
  localparam int DTC_CNT_W      = 4;

endpackage

// File: rtl/dense_train_ctrl.sv
// Sequencer for one dense_layer training step: zero_grad, BATCH_SIZE x
// (forward, load, backward), then update. All outputs are registered.
module dense_train_ctrl
  import dense_train_ctrl_pkg::*;
#(
  parameter int BATCH_SIZE = DTC_BATCH_SIZE,
  parameter int CNT_W      = DTC_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             fwd_data_valid,
  input  logic             bwd_data_valid,
  output logic             fwd_data_ack,
  output logic             bwd_data_ack,
  output logic             zero_grad,
  output logic             run_forward,
  output logic             load_backward,
  output logic             run_backward,
  output logic             update,
  input  logic             valid_zero_grad,
  input  logic             valid_forward,
  input  logic             valid_backward,
  input  logic             valid_update,
  output logic             busy,
  output logic             step_done,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BATCH_SIZE - 1);

  dtc_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fwd_ack;
  logic             r_bwd_ack;
  logic             r_zero;
  logic             r_fwd;
  logic             r_load;
  logic             r_bwd;
  logic             r_upd;
  logic             r_busy;
  logic             r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= DTC_IDLE;
      r_cnt     <= '0;
      r_fwd_ack <= 1'b0;
      r_bwd_ack <= 1'b0;
      r_zero    <= 1'b0;
      r_fwd     <= 1'b0;
      r_load    <= 1'b0;
      r_bwd     <= 1'b0;
      r_upd     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_fwd_ack <= 1'b0;
      r_bwd_ack <= 1'b0;
      r_load    <= 1'b0;
      r_done    <= 1'b0;
      if (abort) begin
        r_state <= DTC_IDLE;
        r_cnt   <= '0;
        r_zero  <= 1'b0;
        r_fwd   <= 1'b0;
        r_bwd   <= 1'b0;
        r_upd   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          DTC_IDLE: if (start) begin
            r_state <= DTC_ZERO;
            r_zero  <= 1'b1;
            r_busy  <= 1'b1;
          end
          DTC_ZERO: if (valid_zero_grad) begin
            r_state <= DTC_FWD_WAIT;
            r_zero  <= 1'b0;
          end
          DTC_FWD_WAIT: if (fwd_data_valid) begin
            r_state   <= DTC_FWD;
            r_fwd     <= 1'b1;
            r_fwd_ack <= 1'b1;
          end
          DTC_FWD: if (valid_forward) begin
            r_state <= DTC_BWD_WAIT;
            r_fwd   <= 1'b0;
          end
          DTC_BWD_WAIT: if (bwd_data_valid) begin
            r_state   <= DTC_LOAD;
            r_load    <= 1'b1;
            r_bwd_ack <= 1'b1;
          end
          // one cycle for the forward-data buffer to settle
          DTC_LOAD: begin
            r_state <= DTC_BWD;
            r_bwd   <= 1'b1;
          end
          DTC_BWD: if (valid_backward) begin
            r_bwd <= 1'b0;
            if (r_cnt == LAST) begin
              r_state <= DTC_UPD;
              r_cnt   <= '0;
              r_upd   <= 1'b1;
            end else begin
              r_state <= DTC_FWD_WAIT;
              r_cnt   <= r_cnt + 1'b1;
            end
          end
          DTC_UPD: if (valid_update) begin
            r_state <= DTC_IDLE;
            r_upd   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
          default: r_state <= DTC_IDLE;
        endcase
      end
    end
  end

  assign fwd_data_ack  = r_fwd_ack;
  assign bwd_data_ack  = r_bwd_ack;
  assign zero_grad     = r_zero;
  assign run_forward   = r_fwd;
  assign load_backward = r_load;
  assign run_backward  = r_bwd;
  assign update        = r_upd;
  assign busy          = r_busy;
  assign step_done     = r_done;
  assign sample_cnt    = r_cnt;

endmodule

// File: tb/tb_dense_train_ctrl.sv
// Directed bench for dense_train_ctrl with BATCH_SIZE=2 and a
// fixed-latency dense_layer model driving the valid inputs.
module tb_dense_train_ctrl;

  localparam int BS = 2;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic fwd_data_valid = 1'b0;
  logic bwd_data_valid = 1'b0;
  logic fwd_data_ack, bwd_data_ack;
  logic zero_grad, run_forward, load_backward;
  logic run_backward, update, busy, step_done;
  logic valid_zero_grad, valid_forward;
  logic valid_backward, valid_update;
  logic [CW-1:0] sample_cnt;

  int   lat = 3;
  logic inj_vf = 1'b0;
  int   c_z = 0, c_f = 0, c_b = 0, c_u = 0;

  int   n_chk = 0;
  int   n_fail = 0;
  byte  ev[$];
  int   n_done = 0, n_fack = 0, n_back = 0;
  logic p_z = 0, p_f = 0, p_b = 0, p_u = 0;
  logic p_fa = 0, p_ba = 0;

  dense_train_ctrl #(.BATCH_SIZE(BS), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .fwd_data_valid  (fwd_data_valid),
    .bwd_data_valid  (bwd_data_valid),
    .fwd_data_ack    (fwd_data_ack),
    .bwd_data_ack    (bwd_data_ack),
    .zero_grad       (zero_grad),
    .run_forward     (run_forward),
    .load_backward   (load_backward),
    .run_backward    (run_backward),
    .update          (update),
    .valid_zero_grad (valid_zero_grad),
    .valid_forward   (valid_forward),
    .valid_backward  (valid_backward),
    .valid_update    (valid_update),
    .busy            (busy),
    .step_done       (step_done),
    .sample_cnt      (sample_cnt)
  );

  always #5 clk = ~clk;

  // dense_layer model: valid rises lat cycles after its run level
  always @(posedge clk) begin
    c_z <= zero_grad    ? c_z + 1 : 0;
    c_f <= run_forward  ? c_f + 1 : 0;
    c_b <= run_backward ? c_b + 1 : 0;
    c_u <= update       ? c_u + 1 : 0;
  end

  assign valid_zero_grad = zero_grad && (c_z >= lat);
  assign valid_forward   = (run_forward && (c_f >= lat)) || inj_vf;
  assign valid_backward  = run_backward && (c_b >= lat);
  assign valid_update    = update && (c_u >= lat);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("onehot0", 32'($onehot0({zero_grad, run_forward,
                                 run_backward, update})), 1);
    chk("fack_2cyc", 32'(p_fa & fwd_data_ack), 0);
    chk("back_2cyc", 32'(p_ba & bwd_data_ack), 0);
    if (zero_grad && !p_z)    ev.push_back("Z");
    if (run_forward && !p_f)  ev.push_back("F");
    if (load_backward)        ev.push_back("L");
    if (run_backward && !p_b) ev.push_back("B");
    if (update && !p_u)       ev.push_back("U");
    if (step_done)    n_done++;
    if (fwd_data_ack) n_fack++;
    if (bwd_data_ack) n_back++;
    p_z  = zero_grad;
    p_f  = run_forward;
    p_b  = run_backward;
    p_u  = update;
    p_fa = fwd_data_ack;
    p_ba = bwd_data_ack;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_log();
    ev.delete();
    n_done = 0;
    n_fack = 0;
    n_back = 0;
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!step_done && k < 2000) begin
      tick();
      k++;
    end
    chk(tag, 32'(step_done), 1);
  endtask

  task automatic chk_seq(input string tag, input string exp);
    chk({tag, "_len"}, ev.size(), exp.len());
    for (int i = 0; i < exp.len() && i < ev.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(ev[i]), 32'(exp[i]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: timeout expected none");
    $fatal(1);
  end

  initial begin
    int   k;
    logic seen;
    int   d0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_levels", 32'({zero_grad, run_forward,
                           load_backward, run_backward,
                           update}), 0);
    chk("rst_pulses", 32'({fwd_data_ack, bwd_data_ack,
                           step_done}), 0);
    chk("rst_cnt", 32'(sample_cnt), 0);
    rst_n = 1'b1;
    tick();

    // 1: full step with feeds always valid
    fwd_data_valid = 1'b1;
    bwd_data_valid = 1'b1;
    lat = 3;
    clr_log();
    kick();
    chk("t1_zero_lat", 32'(zero_grad), 1);
    chk("t1_busy", 32'(busy), 1);
    wait_done("t1_done");
    tick();
    chk("t1_busy_after", 32'(busy), 0);
    chk_seq("t1_seq", "ZFLBFLBU");
    chk("t1_ndone", n_done, 1);
    chk("t1_nfack", n_fack, 2);
    chk("t1_nback", n_back, 2);

    // 2: backward data stalled 50 cycles
    lat = 1;
    bwd_data_valid = 1'b0;
    clr_log();
    kick();
    k = 0;
    while (!run_forward && k < 200) begin tick(); k++; end
    while (run_forward && k < 200) begin tick(); k++; end
    chk("t2_fwd_seen", ev.size(), 2);
    seen = 1'b0;
    repeat (50) begin
      tick();
      seen |= load_backward | run_backward | bwd_data_ack;
    end
    chk("t2_stall", 32'(seen), 0);
    chk("t2_busy", 32'(busy), 1);
    chk("t2_cnt", 32'(sample_cnt), 0);
    bwd_data_valid = 1'b1;
    tick();
    chk("t2_load", 32'({load_backward, bwd_data_ack}), 3);
    chk("t2_nobwd", 32'(run_backward), 0);
    tick();
    chk("t2_bwd", 32'(run_backward), 1);
    chk("t2_load_off", 32'({load_backward, bwd_data_ack}), 0);
    wait_done("t2_done");
    tick();
    chk_seq("t2_seq", "ZFLBFLBU");

    // 3: abort during second backward pass
    lat = 3;
    clr_log();
    kick();
    k = 0;
    while (!(run_backward && sample_cnt == 1) && k < 500) begin
      tick();
      k++;
    end
    chk("t3_reach", 32'({run_backward, sample_cnt}), 32'h5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_levels", 32'({zero_grad, run_forward,
                          load_backward, run_backward,
                          update}), 0);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_cnt", 32'(sample_cnt), 0);
    chk("t3_acks", 32'({fwd_data_ack, bwd_data_ack,
                        step_done}), 0);
    d0 = n_done;
    repeat (5) tick();
    chk("t3_no_done", n_done, d0);
    chk("t3_idle", 32'(busy), 0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("t3_start_abort", 32'({busy, zero_grad}), 0);
    tick();
    chk("t3_still_idle", 32'(busy), 0);

    // 4: stray valid_forward outside FWD
    lat = 5;
    clr_log();
    kick();
    inj_vf = 1'b1;
    tick();
    inj_vf = 1'b0;
    chk("t4_zero_hold", 32'(zero_grad), 1);
    chk("t4_zero_nofwd", 32'({run_forward, fwd_data_ack}), 0);
    k = 0;
    while (!run_backward && k < 500) begin tick(); k++; end
    inj_vf = 1'b1;
    tick();
    inj_vf = 1'b0;
    chk("t4_bwd_hold", 32'(run_backward), 1);
    chk("t4_bwd_nofwd", 32'({run_forward, fwd_data_ack}), 0);
    chk("t4_cnt", 32'(sample_cnt), 0);
    wait_done("t4_done");
    tick();
    chk_seq("t4_seq", "ZFLBFLBU");
    chk("t4_nfack", n_fack, 2);

    // 5: asynchronous reset during update
    lat = 3;
    clr_log();
    kick();
    k = 0;
    while (!update && k < 500) begin tick(); k++; end
    chk("t5_upd", 32'(update), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async", 32'({update, busy, zero_grad,
                         run_forward, run_backward}), 0);
    chk("t5_cnt", 32'(sample_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    clr_log();
    kick();
    wait_done("t5_done");
    tick();
    chk_seq("t5_seq", "ZFLBFLBU");
    chk("t5_ndone", n_done, 1);
    chk("t5_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
